ex_muldiv_stage: RTL and testbench

- Parametrised successor to the combinational EX stage of the MIPS pipeline.
- Adds 4-way forwarding operand muxes, a registered ALU result with valid flag, and signed ADD/SUB overflow detection.
- Adds an iterative multiply/divide unit that owns the HI/LO registers and stalls the front of the pipeline while busy.
- Sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/ex_muldiv_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - EX stage: forwarding muxes, registered ALU, iterative mul/div owning HI/LO
module ex_muldiv_stage #(
    parameter int NB_DATA  = 32,
    parameter int NB_OP    = 6,
    parameter int NB_SEL   = 2,
    parameter int NB_SHAMT = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_sign_extend,
    input  logic [NB_DATA-1:0] i_data_1,
    input  logic [NB_DATA-1:0] i_data_2,
    input  logic [NB_DATA-1:0] i_fwd_mem,
    input  logic [NB_DATA-1:0] i_fwd_wb,
    input  logic [NB_OP-1:0]   i_code,
    input  logic [NB_SEL-1:0]  i_selector_mux_A,
    input  logic [NB_SEL-1:0]  i_selector_mux_B,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic               o_valid,
    output logic               o_overflow,
    output logic               o_stall,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    localparam logic [NB_OP-1:0] OP_ADD   = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_ADDU  = NB_OP'(6'b100001);
    localparam logic [NB_OP-1:0] OP_SUB   = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_SUBU  = NB_OP'(6'b100011);
    localparam logic [NB_OP-1:0] OP_AND   = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR    = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR   = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR   = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SLT   = NB_OP'(6'b101010);
    localparam logic [NB_OP-1:0] OP_SLTU  = NB_OP'(6'b101011);
    localparam logic [NB_OP-1:0] OP_SLLV  = NB_OP'(6'b000100);
    localparam logic [NB_OP-1:0] OP_SRLV  = NB_OP'(6'b000110);
    localparam logic [NB_OP-1:0] OP_SRAV  = NB_OP'(6'b000111);
    localparam logic [NB_OP-1:0] OP_MFHI  = NB_OP'(6'b010000);
    localparam logic [NB_OP-1:0] OP_MFLO  = NB_OP'(6'b010010);
    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(6'b011000);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(6'b011010);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(6'b011011);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t                 state_q, state_d;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;
    logic [2*NB_DATA-1:0]   acc_q, acc_d;
    logic [NB_DATA-1:0]     opnd_q, opnd_d;
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   dvz_q, dvz_d;
    logic [NB_DATA-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [NB_DATA-1:0]     alu_q, alu_d;
    logic                   valid_q, valid_d, ovf_q, ovf_d;

    logic [NB_DATA-1:0]     op_a, op_b, sum, diff, alu_res, mag_a, mag_b;
    logic [NB_SHAMT-1:0]    shamt;
    logic                   alu_ovf, is_mul, is_div, is_signed_md, last;
    logic [NB_DATA:0]       mul_sum, div_trial;
    logic [2*NB_DATA-1:0]   mul_step, div_step, mul_prod;
    logic [NB_DATA-1:0]     div_q, div_r;

    always_comb begin
        case (i_selector_mux_A)
            2'b00:   op_a = i_data_1;
            2'b01:   op_a = i_pc;
            2'b10:   op_a = i_fwd_mem;
            default: op_a = i_fwd_wb;
        endcase
        case (i_selector_mux_B)
            2'b00:   op_b = i_data_2;
            2'b01:   op_b = i_sign_extend;
            2'b10:   op_b = i_fwd_mem;
            default: op_b = i_fwd_wb;
        endcase
    end

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_a[NB_SHAMT-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (i_code)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[NB_DATA-1] == op_b[NB_DATA-1]) && (sum[NB_DATA-1] != op_a[NB_DATA-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[NB_DATA-1] != op_b[NB_DATA-1]) && (diff[NB_DATA-1] != op_a[NB_DATA-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, (op_a < op_b)};
            OP_SLLV: alu_res = op_b << shamt;
            OP_SRLV: alu_res = op_b >> shamt;
            OP_SRAV: alu_res = $signed(op_b) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign is_mul       = (i_code == OP_MULT) || (i_code == OP_MULTU);
    assign is_div       = (i_code == OP_DIV)  || (i_code == OP_DIVU);
    assign is_signed_md = (i_code == OP_MULT) || (i_code == OP_DIV);
    assign mag_a = (is_signed_md && op_a[NB_DATA-1]) ? -op_a : op_a;
    assign mag_b = (is_signed_md && op_b[NB_DATA-1]) ? -op_b : op_b;
    assign last  = (cnt_q == CNT_LAST);

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step  = {mul_sum, acc_q[NB_DATA-1:1]};
    assign div_trial = acc_q[2*NB_DATA-1:NB_DATA-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[NB_DATA] ? {acc_q[2*NB_DATA-2:0], 1'b0}
                                          : {div_trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
    assign mul_prod  = neg_res_q ? -mul_step : mul_step;
    assign div_r     = div_step[2*NB_DATA-1:NB_DATA];
    assign div_q     = div_step[NB_DATA-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && is_mul)      state_d = ST_MUL;
                else if (i_valid && is_div) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: if (last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_stall = (state_q != ST_IDLE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dvz_d     = dvz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        alu_d     = alu_q;
        valid_d   = 1'b0;
        ovf_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && (is_mul || is_div)) begin
                    cnt_d     = '0;
                    acc_d     = {{NB_DATA{1'b0}}, mag_a};
                    opnd_d    = mag_b;
                    neg_res_d = is_signed_md && (op_a[NB_DATA-1] ^ op_b[NB_DATA-1]);
                    neg_rem_d = is_signed_md && op_a[NB_DATA-1];
                    dvz_d     = (op_b == '0);
                end else if (i_valid) begin
                    alu_d   = alu_res;
                    valid_d = 1'b1;
                    ovf_d   = alu_ovf;
                end
            end
            ST_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    hi_d  = mul_prod[2*NB_DATA-1:NB_DATA];
                    lo_d  = mul_prod[NB_DATA-1:0];
                end
            end
            ST_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    lo_d  = dvz_q ? '1 : (neg_res_q ? -div_q : div_q);
                    hi_d  = neg_rem_q ? -div_r : div_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            alu_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dvz_q     <= dvz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            alu_q     <= alu_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_alu_result = alu_q;
    assign o_valid      = valid_q;
    assign o_overflow   = ovf_q;
    assign o_hi         = hi_q;
    assign o_lo         = lo_q;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - directed bench for ex_muldiv_stage
module tb_ex_muldiv_stage;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_pc, i_sign_extend, i_data_1, i_data_2, i_fwd_mem, i_fwd_wb;
    logic [5:0]  i_code;
    logic [1:0]  i_selector_mux_A, i_selector_mux_B;
    logic [31:0] o_alu_result, o_hi, o_lo;
    logic        o_valid, o_overflow, o_stall;

    int total = 0;
    int bad   = 0;

    ex_muldiv_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc(i_pc),
        .i_sign_extend(i_sign_extend), .i_data_1(i_data_1), .i_data_2(i_data_2),
        .i_fwd_mem(i_fwd_mem), .i_fwd_wb(i_fwd_wb), .i_code(i_code),
        .i_selector_mux_A(i_selector_mux_A), .i_selector_mux_B(i_selector_mux_B),
        .o_alu_result(o_alu_result), .o_valid(o_valid), .o_overflow(o_overflow),
        .o_stall(o_stall), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_code = code;
        i_selector_mux_A = 2'b00;
        i_selector_mux_B = 2'b00;
        i_data_1 = a;
        i_data_2 = b;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (o_stall && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        issue(6'b100000, 32'h1, 32'h2);
        #2 i_reset = 1'b1;
        #1;
        total++; if (o_alu_result !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", o_alu_result); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_overflow !== 1'b0 || o_stall !== 1'b0) begin bad++; $display("FAIL reset_ovf_stall got=%b%b exp=00", o_overflow, o_stall); end
        total++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", o_hi, o_lo); end
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_alu_forwarding();
        issue(6'b100000, 32'h0000000F, 32'h000000F0);
        total++; if (o_alu_result !== 32'h000000FF || o_valid !== 1'b1) begin bad++; $display("FAIL add_basic got=%h v=%b exp=000000ff v=1", o_alu_result, o_valid); end
        i_valid = 1'b1; i_code = 6'b100000;
        i_selector_mux_A = 2'b10; i_fwd_mem = 32'd5;
        i_selector_mux_B = 2'b01; i_sign_extend = 32'd1;
        tick();
        total++; if (o_alu_result !== 32'h00000006) begin bad++; $display("FAIL add_fwd got=%h exp=00000006", o_alu_result); end
        i_code = 6'b100101;
        i_selector_mux_A = 2'b11; i_fwd_wb = 32'hF0F00000;
        i_selector_mux_B = 2'b10; i_fwd_mem = 32'h00000F0F;
        tick();
        total++; if (o_alu_result !== 32'hF0F00F0F) begin bad++; $display("FAIL or_fwd got=%h exp=f0f00f0f", o_alu_result); end
        i_code = 6'b100010;
        i_selector_mux_A = 2'b01; i_pc = 32'h00001000;
        i_selector_mux_B = 2'b00; i_data_2 = 32'h00000010;
        tick();
        total++; if (o_alu_result !== 32'h00000FF0) begin bad++; $display("FAIL sub_pc got=%h exp=00000ff0", o_alu_result); end
        i_valid = 1'b0;
        tick();
        total++; if (o_valid !== 1'b0 || o_alu_result !== 32'h00000FF0) begin bad++; $display("FAIL idle_hold got=%h v=%b exp=00000ff0 v=0", o_alu_result, o_valid); end
        issue(6'b111111, 32'h5, 32'h6);
        total++; if (o_alu_result !== 32'h0 || o_valid !== 1'b1) begin bad++; $display("FAIL unknown got=%h v=%b exp=0 v=1", o_alu_result, o_valid); end
    endtask

    task automatic test_overflow_wrap();
        issue(6'b100000, 32'h7FFFFFFF, 32'h1);
        total++; if (o_alu_result !== 32'h80000000 || o_overflow !== 1'b1) begin bad++; $display("FAIL add_ovf got=%h o=%b exp=80000000 o=1", o_alu_result, o_overflow); end
        issue(6'b100001, 32'h7FFFFFFF, 32'h1);
        total++; if (o_alu_result !== 32'h80000000 || o_overflow !== 1'b0) begin bad++; $display("FAIL addu got=%h o=%b exp=80000000 o=0", o_alu_result, o_overflow); end
        issue(6'b100010, 32'h80000000, 32'h1);
        total++; if (o_alu_result !== 32'h7FFFFFFF || o_overflow !== 1'b1) begin bad++; $display("FAIL sub_ovf got=%h o=%b exp=7fffffff o=1", o_alu_result, o_overflow); end
        issue(6'b101010, 32'hFFFFFFFF, 32'h1);
        total++; if (o_alu_result !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=1", o_alu_result); end
        issue(6'b101011, 32'hFFFFFFFF, 32'h1);
        total++; if (o_alu_result !== 32'h0) begin bad++; $display("FAIL sltu got=%h exp=0", o_alu_result); end
        issue(6'b000111, 32'h4, 32'h80000000);
        total++; if (o_alu_result !== 32'hF8000000) begin bad++; $display("FAIL srav got=%h exp=f8000000", o_alu_result); end
        issue(6'b000110, 32'h4, 32'h80000000);
        total++; if (o_alu_result !== 32'h08000000) begin bad++; $display("FAIL srlv got=%h exp=08000000", o_alu_result); end
        issue(6'b000100, 32'h24, 32'h00000003);
        total++; if (o_alu_result !== 32'h00000030) begin bad++; $display("FAIL sllv got=%h exp=00000030", o_alu_result); end
        issue(6'b100111, 32'h0F0F0F0F, 32'h00FF00FF);
        total++; if (o_alu_result !== 32'hF000F000) begin bad++; $display("FAIL nor got=%h exp=f000f000", o_alu_result); end
    endtask

    task automatic test_mult();
        int cycles;
        issue(6'b011000, 32'hFFFFFFFD, 32'h7);
        total++; if (o_valid !== 1'b0 || o_stall !== 1'b1) begin bad++; $display("FAIL mult_accept v=%b s=%b exp v=0 s=1", o_valid, o_stall); end
        wait_idle(cycles);
        total++; if (cycles !== 32) begin bad++; $display("FAIL mult_stall_len got=%0d exp=32", cycles); end
        total++; if (o_hi !== 32'hFFFFFFFF || o_lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_hilo got=%h/%h exp=ffffffff/ffffffeb", o_hi, o_lo); end
        issue(6'b010010, 32'h0, 32'h0);
        total++; if (o_alu_result !== 32'hFFFFFFEB || o_valid !== 1'b1) begin bad++; $display("FAIL mflo got=%h v=%b exp=ffffffeb v=1", o_alu_result, o_valid); end
        issue(6'b010000, 32'h0, 32'h0);
        total++; if (o_alu_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi got=%h exp=ffffffff", o_alu_result); end
        issue(6'b011001, 32'h00010000, 32'h00010000);
        wait_idle(cycles);
        total++; if (o_hi !== 32'h1 || o_lo !== 32'h0) begin bad++; $display("FAIL multu_big got=%h/%h exp=1/0", o_hi, o_lo); end
    endtask

    task automatic test_div();
        int cycles;
        issue(6'b011010, 32'hFFFFFFF9, 32'h2);
        wait_idle(cycles);
        total++; if (o_lo !== 32'hFFFFFFFD || o_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg got=%h/%h exp=lo fffffffd hi ffffffff", o_lo, o_hi); end
        issue(6'b011011, 32'h7, 32'h0);
        wait_idle(cycles);
        total++; if (cycles !== 32) begin bad++; $display("FAIL divz_len got=%0d exp=32", cycles); end
        total++; if (o_lo !== 32'hFFFFFFFF || o_hi !== 32'h7) begin bad++; $display("FAIL divu_zero got=%h/%h exp=lo ffffffff hi 7", o_lo, o_hi); end
        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cycles);
        total++; if (o_lo !== 32'h80000000 || o_hi !== 32'h0) begin bad++; $display("FAIL div_minneg got=%h/%h exp=lo 80000000 hi 0", o_lo, o_hi); end
        issue(6'b011011, 32'd100, 32'd7);
        wait_idle(cycles);
        total++; if (o_lo !== 32'd14 || o_hi !== 32'd2) begin bad++; $display("FAIL divu got=%h/%h exp=lo e hi 2", o_lo, o_hi); end
    endtask

    task automatic test_busy_reset();
        int cycles;
        int busy_bad;
        logic [31:0] held;
        issue(6'b100001, 32'h11, 32'h22);
        held = 32'h33;
        issue(6'b011001, 32'h2, 32'h3);
        busy_bad = 0;
        i_valid = 1'b1; i_code = 6'b100000; i_data_1 = 32'h5; i_data_2 = 32'h5;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_valid !== 1'b0 || o_alu_result !== held || o_lo !== 32'd14 || o_stall !== 1'b1) busy_bad++;
        end
        i_valid = 1'b0;
        total++; if (busy_bad != 0) begin bad++; $display("FAIL busy_ignore got=%0d bad cycles exp=0", busy_bad); end
        wait_idle(cycles);
        total++; if (o_lo !== 32'd6 || o_hi !== 32'd0) begin bad++; $display("FAIL busy_result got=%h/%h exp=6/0", o_lo, o_hi); end
        issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 10; k++) tick();
        i_reset = 1'b1;
        #1;
        total++; if (o_hi !== 32'h0 || o_lo !== 32'h0 || o_stall !== 1'b0) begin bad++; $display("FAIL midop_reset got=%h/%h s=%b exp=0/0 s=0", o_hi, o_lo, o_stall); end
        tick();
        i_reset = 1'b0;
        issue(6'b011001, 32'd3, 32'd4);
        wait_idle(cycles);
        total++; if (o_lo !== 32'd12 || o_hi !== 32'd0 || cycles !== 32) begin bad++; $display("FAIL post_reset_mult got=%h/%h n=%0d exp=c/0 n=32", o_lo, o_hi, cycles); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_pc = '0; i_sign_extend = '0; i_data_1 = '0; i_data_2 = '0;
        i_fwd_mem = '0; i_fwd_wb = '0; i_code = '0;
        i_selector_mux_A = '0; i_selector_mux_B = '0;
        tick();
        tick();
        i_reset = 1'b0;
        test_reset();
        test_alu_forwarding();
        test_overflow_wrap();
        test_mult();
        test_div();
        test_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
